// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory between instruction fetch (IF) and load/store (D).
// D has priority; a starvation counter forces an IF win after STARVE_MAX lost contests.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned       CNT_W      = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t            r_state,     w_state_nxt;
   logic              r_owner_d,   w_owner_d_nxt;
   logic              r_rd,        w_rd_nxt;
   logic [CNT_W-1:0]  r_starve,    w_starve_nxt;
   logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
   logic              r_if_gnt,    w_if_gnt_nxt;
   logic              r_d_gnt,     w_d_gnt_nxt;
   logic              r_if_done,   w_if_done_nxt;
   logic              r_d_done,    w_d_done_nxt;
   logic              r_mem_en,    w_mem_en_nxt;
   logic              r_mem_we,    w_mem_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_nxt;
   logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;
   logic              w_pick_d;

   // D wins unless contested while IF has already lost STARVE_MAX times in a row
   assign w_pick_d = d_req && (!if_req || (r_starve < STARVE_LIM));

   always_comb begin
      w_state_nxt     = r_state;
      w_owner_d_nxt   = r_owner_d;
      w_rd_nxt        = r_rd;
      w_starve_nxt    = r_starve;
      w_cnt_nxt       = r_cnt;
      w_if_gnt_nxt    = 1'b0;
      w_d_gnt_nxt     = 1'b0;
      w_if_done_nxt   = 1'b0;
      w_d_done_nxt    = 1'b0;
      w_mem_en_nxt    = 1'b0;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_if_rdata_nxt  = r_if_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      case (r_state)
         S_IDLE: begin
            if (if_req || d_req) begin
               w_state_nxt    = S_ISSUE;
               w_owner_d_nxt  = w_pick_d;
               w_rd_nxt       = w_pick_d ? !d_we : 1'b1;
               w_mem_addr_nxt = w_pick_d ? d_addr : if_addr;
               if (w_pick_d) w_mem_wdata_nxt = d_wdata;
               w_mem_we_nxt   = w_pick_d && d_we;
               w_mem_en_nxt   = 1'b1;
               w_d_gnt_nxt    = w_pick_d;
               w_if_gnt_nxt   = !w_pick_d;
               if (!w_pick_d)   w_starve_nxt = '0;
               else if (if_req) w_starve_nxt = r_starve + CNT_W'(1);
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = LAT_LOAD;
            w_state_nxt = (LAT_LOAD == '0) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            if (r_owner_d) begin
               w_d_done_nxt = 1'b1;
               if (r_rd) w_d_rdata_nxt = mem_rdata;
            end else begin
               w_if_done_nxt  = 1'b1;
               w_if_rdata_nxt = mem_rdata;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_owner_d   <= 1'b0;
         r_rd        <= 1'b0;
         r_starve    <= '0;
         r_cnt       <= '0;
         r_if_gnt    <= 1'b0;
         r_d_gnt     <= 1'b0;
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner_d   <= w_owner_d_nxt;
         r_rd        <= w_rd_nxt;
         r_starve    <= w_starve_nxt;
         r_cnt       <= w_cnt_nxt;
         r_if_gnt    <= w_if_gnt_nxt;
         r_d_gnt     <= w_d_gnt_nxt;
         r_if_done   <= w_if_done_nxt;
         r_d_done    <= w_d_done_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_if_rdata  <= w_if_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
      end
   end

   assign if_gnt    = r_if_gnt;
   assign d_gnt     = r_d_gnt;
   assign if_done   = r_if_done;
   assign d_done    = r_d_done;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between two requesters in the multicycle core: the instruction-fetch path (IF) and the load/store data path (D).
- Sequences each access: arbitration, one-cycle issue, fixed memory latency wait, response capture, done pulse.
- Sits between the control unit / datapath request logic and the memory macro.
- D has priority; an anti-starvation counter bounds how long IF can be blocked.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the issue cycle until mem_rdata is valid (legal range 1..15).
- STARVE_MAX, 3, number of consecutive contested arbitrations IF may lose before it is forced to win (legal range 0..15; 0 means IF wins every contest).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low.
- if_req  in  1  IF request; held high with if_addr stable until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse in the IF issue cycle.
- if_done  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DATA_W  registered fetch data; holds its value until the next IF read completes.
- d_req  in  1  data request; held high with d_we/d_addr/d_wdata stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse in the D issue cycle.
- d_done  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
- d_rdata  out  DATA_W  registered load data; unchanged by stores.
- mem_en  out  1  memory access strobe; high only in the issue cycle.
- mem_we  out  1  write strobe; high only in the issue cycle of a store.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after the issue cycle.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state = IDLE.
  - All strobes (gnt, done, mem_en, mem_we) = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - Starvation counter and wait counter = 0.
  - Reset mid-access abandons the access: no done pulse is produced and the rdata registers are cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE. If neither req is high, stay in IDLE.
  - Winner selection:
    - Only one req high: that requester wins.
    - Both high and starve_cnt < STARVE_MAX: D wins, starve_cnt increments.
    - Both high and starve_cnt >= STARVE_MAX: IF wins.
  - starve_cnt clears to 0 whenever IF wins.
  - On the transition to ISSUE, latch the owner, mem_addr and mem_wdata; mem_we is latched as d_we for a D access and 0 for an IF access.
- ISSUE (1 cycle):
  - mem_en = 1; owner's gnt = 1; mem_we = 1 for stores only.
  - Load wait counter with MEM_LAT-1; next state WAIT, or RESP directly when MEM_LAT==1.
- WAIT:
  - Counter decrements each cycle; go to RESP when it reaches 0.
  - mem_en = 0; mem_addr holds its value.
- RESP (1 cycle):
  - mem_rdata is valid. For a read, capture it into the owner's rdata register at the end of this cycle.
- Done pulse:
  - The owner's done pulse occurs in the cycle after RESP, together with valid rdata.
  - The state machine is back in IDLE in that same cycle.
- Latency: req first high in IDLE cycle T, no contention → gnt/mem_en at T+1, mem_rdata valid at T+1+MEM_LAT, done at T+2+MEM_LAT (T+4 for the default MEM_LAT).
- Requester rule: clear req at the edge where done is sampled high. req is then low in the IDLE cycle in which done is asserted, so no duplicate grant occurs.
- Back-to-back: a pending other requester is sampled in that same IDLE cycle and is issued the following cycle, so there is no idle gap beyond the done cycle.
- Requests that arrive while not in IDLE wait; they are never dropped.
- Stores: d_rdata unchanged; d_done still pulses at the same latency.
- if_gnt and d_gnt are never high together; likewise if_done and d_done.

Test Plan:
- Single IF read: reset released; if_req=1, if_addr=0x40 at cycle 0 → if_gnt, mem_en=1, mem_addr=0x40 at cycle 1; mem_rdata=0x2002000A driven at cycle 3 → if_done=1, if_rdata=0x2002000A at cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → exactly one cycle with mem_en=mem_we=1 and those values; d_done 3 cycles later; d_rdata unchanged.
- Contention with starvation (STARVE_MAX=3): both reqs held continuously → grant order D, D, D, IF, D, ...; IF never waits more than 3 contested arbitrations.
- Back-to-back: D completes while if_req is pending → IF issue occurs in the cycle after d_done; no gnt overlap.
- Reset mid-WAIT: reset=0 during WAIT → next cycle all outputs 0, state IDLE, no done pulse; a new request afterwards completes normally.
- MEM_LAT=1 and MEM_LAT=5 builds: done at T+3 and T+7 respectively; rdata matches mem_rdata sampled at T+1+MEM_LAT.
